multdiv_sequencer: RTL and testbench

Controller that sequences the shared multi-cycle multiply/divide unit for the 5-stage pipeline. It accepts one mult/div issue from execute, latches operands and destination, pulses the unit's start strobe, and holds the pipeline stall while the operation runs. On completion it produces a single-cycle writeback record, with exception codes redirected to $rstatus (r30). Watchdog timeout and pipeline flush are handled explicitly.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_watchdog.sv | 43 ++++
 rtl/multdiv_sequencer.sv | 132 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Purpose  : Shared definitions for the multiply/divide sequencer: FSM state
//             encoding, the $rstatus register index and the exception codes
//             written there.
//  Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } md_state_t;

  localparam logic [4:0]  RSTATUS_REG   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

  // Exception code written to $rstatus for the given operation type.
  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? DIV_EXC_CODE : MULT_EXC_CODE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : md_watchdog
//  Purpose  : Saturating cycle counter that flags when an operation has been
//             running for TIMEOUT cycles.
//  Ports    : clock     - master clock
//             reset     - asynchronous active-low reset
//             i_clear   - synchronous clear to zero (priority over enable)
//             i_enable  - count one cycle
//             o_expired - counter value equals TIMEOUT
//  Revision : 1.0 - initial release
// ============================================================================
module md_watchdog
  import md_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != C_LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_sequencer
//  Purpose  : Sequences the shared multi-cycle mult/div unit. Accepts one
//             issue from execute, latches operands/destination, pulses the
//             unit start strobe, stalls the pipeline while the unit runs and
//             emits a one-cycle writeback record. Unit exceptions and watchdog
//             timeouts are redirected to $rstatus (r30).
//  Ports    : clock, reset (async active-low)
//             issue_mult/issue_div/flush, operand_a/b, dest_reg  - execute side
//             md_resultRDY/md_result/md_exception                - unit result
//             ctrl_MULT/ctrl_DIV/md_a/md_b                       - unit control
//             stall/busy                                         - pipeline
//             wb_valid/wb_reg/wb_data                            - writeback
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_sequencer
  import md_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mult,
  input  logic        issue_div,
  input  logic        flush,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  dest_reg,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  md_state_t  r_state;
  logic       r_is_div;
  logic [4:0] r_dest;

  logic w_issue;
  logic w_expired;
  logic w_in_start;
  logic w_in_run;
  logic w_in_done;

  assign w_issue    = (issue_mult | issue_div) & ~flush;
  assign w_in_start = (r_state == START);
  assign w_in_run   = (r_state == RUN);
  assign w_in_done  = (r_state == DONE);

  md_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_in_start),
    .i_enable  (w_in_run),
    .o_expired (w_expired)
  );

  // wb_reg/wb_data are loaded on the edge into DONE so they are valid during
  // the DONE cycle and then simply hold until the next completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_is_div <= 1'b0;
      r_dest   <= '0;
      md_a     <= '0;
      md_b     <= '0;
      wb_reg   <= '0;
      wb_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            md_a     <= operand_a;
            md_b     <= operand_b;
            r_dest   <= dest_reg;
            r_is_div <= ~issue_mult;   // mult wins when both are raised
            r_state  <= START;
          end
        end
        START: begin
          r_state <= flush ? IDLE : RUN;
        end
        RUN: begin
          if (flush) begin
            r_state <= IDLE;
          end else if (md_resultRDY) begin
            // A result arriving on the timeout cycle still takes priority.
            wb_reg  <= md_exception ? RSTATUS_REG : r_dest;
            wb_data <= md_exception ? exc_code(r_is_div) : md_result;
            r_state <= DONE;
          end else if (w_expired) begin
            wb_reg  <= RSTATUS_REG;
            wb_data <= exc_code(r_is_div);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Flush squashes the start strobe and writeback in the same cycle.
  assign ctrl_MULT = w_in_start & ~r_is_div & ~flush;
  assign ctrl_DIV  = w_in_start &  r_is_div & ~flush;
  assign wb_valid  = w_in_done & ~flush;
  assign busy      = (r_state != IDLE);

  // The issue-cycle term depends on raw inputs; gating with reset keeps the
  // output quiet while reset is held.
  assign stall = (reset & (r_state == IDLE) & w_issue) |
                 ((w_in_start | w_in_run) & ~flush);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_sequencer
//  Purpose  : Directed self-checking bench for multdiv_sequencer. Each
//             operation is described by its issue cycle, the cycle its
//             writeback is due and an optional flush cycle; a per-cycle
//             compare process derives expected outputs from those.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 64;
  localparam int NONE    = 1 << 30;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_mult = 1'b0, issue_div = 1'b0, flush = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [4:0]  dest_reg = '0;
  logic        md_resultRDY = 1'b0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, wb_valid;
  logic [31:0] md_a, md_b, wb_data;
  logic [4:0]  wb_reg;

  multdiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clock(clock), .reset(reset), .issue_mult(issue_mult), .issue_div(issue_div),
    .flush(flush), .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .md_resultRDY(md_resultRDY), .md_result(md_result), .md_exception(md_exception),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .md_a(md_a), .md_b(md_b),
    .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the operation currently in flight (transaction level).
  bit          m_on   = 1'b0;
  bit          m_mult = 1'b0;
  int          m_i = 0, m_w = 0, m_f = NONE;
  logic [31:0] m_a = '0, m_b = '0, m_data = '0;
  logic [4:0]  m_reg = '0;

  bit e_busy, e_stall, e_cm, e_cd, e_wbv;

  always @(negedge clock) begin
    if (!reset) begin
      check("rst_ctrl_MULT", {31'd0, ctrl_MULT}, 0);
      check("rst_ctrl_DIV",  {31'd0, ctrl_DIV},  0);
      check("rst_stall",     {31'd0, stall},     0);
      check("rst_busy",      {31'd0, busy},      0);
      check("rst_wb_valid",  {31'd0, wb_valid},  0);
      check("rst_wb_reg",    {27'd0, wb_reg},    0);
      check("rst_wb_data",   wb_data,            0);
      check("rst_md_a",      md_a,               0);
      check("rst_md_b",      md_b,               0);
    end else begin
      e_busy  = m_on && cyc >= m_i + 1 && cyc <= m_w && cyc <= m_f;
      e_stall = m_on && cyc >= m_i && cyc < m_w && cyc < m_f;
      e_cm    = m_on && cyc == m_i + 1 && m_f != m_i + 1 && m_mult;
      e_cd    = m_on && cyc == m_i + 1 && m_f != m_i + 1 && !m_mult;
      e_wbv   = m_on && cyc == m_w && m_f > m_w;
      check("busy",      {31'd0, busy},      {31'd0, e_busy});
      check("stall",     {31'd0, stall},     {31'd0, e_stall});
      check("ctrl_MULT", {31'd0, ctrl_MULT}, {31'd0, e_cm});
      check("ctrl_DIV",  {31'd0, ctrl_DIV},  {31'd0, e_cd});
      check("wb_valid",  {31'd0, wb_valid},  {31'd0, e_wbv});
      if (e_wbv) begin
        check("wb_reg",  {27'd0, wb_reg}, {27'd0, m_reg});
        check("wb_data", wb_data, m_data);
      end
      if (e_busy) begin
        check("md_a", md_a, m_a);
        check("md_b", md_b, m_b);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run one operation. rdy_k: RUN cycle (1-based) in which RDY is raised,
  // 0 = never. flush_k: cycle offset after issue at which flush is raised,
  // 0 = none. lit_t: offset at which a hand-computed writeback is checked.
  task automatic run_op(input bit do_mult, input bit do_div,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest,
                        input logic [31:0] res, input bit exc, input int rdy_k,
                        input int flush_k, input int late_rdy_k, input bit issue_flush,
                        input bit issue_in_done, input int reset_t,
                        input int lit_t, input logic [4:0] lit_reg, input logic [31:0] lit_data);
    int  i0, w, f, keff, last;
    bit  tmo, mult_kind;
    i0        = cyc;
    mult_kind = do_mult;
    tmo       = (rdy_k == 0) || (rdy_k > TIMEOUT + 1);
    keff      = tmo ? TIMEOUT + 1 : rdy_k;
    w         = i0 + 2 + keff;
    f         = (flush_k > 0) ? i0 + flush_k : NONE;
    if (!issue_flush) begin
      m_on = 1'b1; m_mult = mult_kind; m_i = i0; m_w = w; m_f = f;
      m_a = a; m_b = b;
      m_reg  = (tmo || exc) ? 5'd30 : dest;
      m_data = (tmo || exc) ? (mult_kind ? 32'd4 : 32'd5) : res;
    end
    issue_mult = do_mult; issue_div = do_div; flush = issue_flush;
    operand_a = a; operand_b = b; dest_reg = dest;
    tick();
    issue_mult = 1'b0; issue_div = 1'b0; flush = 1'b0;
    operand_a = $urandom; operand_b = $urandom; dest_reg = 5'($urandom);
    last = issue_flush ? 1 : (((f < w) ? f : w) - i0 + 2);
    for (int t = 1; t <= last; t++) begin
      if (t == lit_t) begin
        check("lit_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("lit_wb_reg",   {27'd0, wb_reg},   {27'd0, lit_reg});
        check("lit_wb_data",  wb_data,           lit_data);
      end
      md_resultRDY = (!tmo && t == 1 + rdy_k) || (late_rdy_k > 0 && t == 1 + late_rdy_k);
      md_result    = res;
      md_exception = exc;
      flush        = (cyc == f);
      issue_mult   = issue_in_done && (cyc == w);
      if (t == reset_t) begin
        #1 reset = 1'b0;
        m_on = 1'b0;
        #1;
        check("async_rst_busy",  {31'd0, busy},  0);
        check("async_rst_stall", {31'd0, stall}, 0);
        check("async_rst_md_a",  md_a,           0);
        check("async_rst_wb",    wb_data,        0);
        md_resultRDY = 1'b0;
        tick(); tick();
        reset = 1'b1;
        break;
      end
      tick();
    end
    md_resultRDY = 1'b0; md_exception = 1'b0; flush = 1'b0; issue_mult = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    // 6*7 -> r5, RDY 32 cycles after the start pulse; writeback due 34 after issue.
    run_op(1, 0, 32'd6, 32'd7, 5'd5, 32'd6 * 32'd7, 0, 32, 0, 0, 0, 0, 0, 34, 5'd5, 32'd42);
    // 7/0 -> unit exception, r30 <= 5.
    run_op(0, 1, 32'd7, 32'd0, 5'd9, 32'hDEAD_BEEF, 1, 10, 0, 0, 0, 0, 0, 12, 5'd30, 32'd5);
    // Both issues: mult wins.
    run_op(1, 1, 32'd100, 32'd3, 5'd12, 32'd300, 0, 4, 0, 0, 0, 0, 0, 6, 5'd12, 32'd300);
    // Flush 5 cycles into RUN, late RDY afterwards must be ignored.
    run_op(1, 0, 32'd2, 32'd9, 5'd7, 32'd18, 0, 0, 6, 6, 0, 0, 0, 0, 5'd0, 32'd0);
    // Flush during START: no start pulse.
    run_op(0, 1, 32'd40, 32'd8, 5'd3, 32'd5, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'd0);
    // Flush during DONE: no writeback strobe.
    run_op(1, 0, 32'd3, 32'd3, 5'd4, 32'd9, 0, 3, 5, 0, 0, 0, 0, 0, 5'd0, 32'd0);
    // Issue together with flush in IDLE is blocked.
    run_op(1, 0, 32'd1, 32'd1, 5'd1, 32'd1, 0, 2, 0, 0, 1, 0, 0, 0, 5'd0, 32'd0);
    // Timeout on a mult: 65 RUN cycles, r30 <= 4.
    run_op(1, 0, 32'd11, 32'd13, 5'd8, 32'd143, 0, 0, 0, 0, 0, 0, 0, 67, 5'd30, 32'd4);
    // RDY in the same cycle as the timeout: result wins.
    run_op(0, 1, 32'd99, 32'd9, 5'd6, 32'd11, 0, 65, 0, 0, 0, 0, 0, 67, 5'd6, 32'd11);
    // dest 0 still writes back; an issue presented in DONE is dropped.
    run_op(0, 1, 32'd50, 32'd5, 5'd0, 32'd10, 0, 1, 0, 0, 0, 1, 0, 3, 5'd0, 32'd10);
    // Async reset mid-RUN, then a normal op.
    run_op(1, 0, 32'd4, 32'd4, 5'd2, 32'd16, 0, 0, 0, 0, 0, 0, 12, 0, 5'd0, 32'd0);
    run_op(1, 0, 32'hFFFF_FFFF, 32'd2, 5'd31, 32'hFFFF_FFFE, 0, 2, 0, 0, 0, 0, 0, 4, 5'd31, 32'hFFFF_FFFE);
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
